// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: named truth tables
// and the 2-input lookup used by every bit slice.
package logic_unit_pipe_pkg;

  localparam logic [3:0] OP_ZERO   = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b1000;
  localparam logic [3:0] OP_OR     = 4'b1110;
  localparam logic [3:0] OP_XOR    = 4'b0110;
  localparam logic [3:0] OP_NAND   = 4'b0111;
  localparam logic [3:0] OP_PASS_A = 4'b1100;
  localparam logic [3:0] OP_PASS_B = 4'b1010;
  localparam logic [3:0] OP_ONES   = 4'b1111;

  // Truth-table lookup: the operand pair {a,b} selects one bit of op.
  function automatic logic lut2(input logic [3:0] op, input logic a, input logic b);
    return op[{a, b}];
  endfunction

endpackage

// File: rtl/logic_unit_bit.sv
// One bit slice of the logic unit: a 2-input function chosen by a 4-bit truth table.
module logic_unit_bit
  import logic_unit_pipe_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [3:0] op,
  output logic       f
);

  assign f = lut2(op, a, b);

endmodule

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit truth-table logic unit with a two-stage valid/ready pipeline,
// accumulator feedback for operand B, result flags and a delivered-beat counter.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_f_q, s1_f_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_f_q, s2_f_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             s2_adv, s1_adv, accept, deliver;
  logic [WIDTH-1:0] op_b, f;

  // Back-pressure ripples combinationally from the consumer; no skid buffer.
  assign s2_adv   = !s2_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & s1_adv;
  assign deliver  = s2_valid_q & out_ready;

  // A clear coinciding with an accumulate beat must already see zero.
  always_comb begin
    op_b = in_b;
    if (in_acc) op_b = acc_clr ? '0 : acc_q;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic_unit_bit u_bit (
      .a  (in_a[gi]),
      .b  (op_b[gi]),
      .op (in_op),
      .f  (f[gi])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_f_d     = s1_f_q;
    s2_valid_d = s2_valid_q;
    s2_f_d     = s2_f_q;
    zero_d     = zero_q;
    ones_d     = ones_q;
    parity_d   = parity_q;
    acc_d      = acc_q;
    count_d    = count_q;

    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) s1_f_d = f;
    end

    // S2 keeps its last data when it empties, so a stalled result never moves.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_f_d   = s1_f_q;
        zero_d   = (s1_f_q == '0);
        ones_d   = (s1_f_q == '1);
        parity_d = ^s1_f_q;
      end
    end

    if (accept)       acc_d = f;
    else if (acc_clr) acc_d = '0;

    if (deliver) count_d = count_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_f_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_f_q     <= '0;
      zero_q     <= 1'b0;
      ones_q     <= 1'b0;
      parity_q   <= 1'b0;
      acc_q      <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_f_q     <= s1_f_d;
      s2_valid_q <= s2_valid_d;
      s2_f_q     <= s2_f_d;
      zero_q     <= zero_d;
      ones_q     <= ones_d;
      parity_q   <= parity_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_f      = s2_f_q;
  assign out_zero   = zero_q;
  assign out_ones   = ones_q;
  assign out_parity = parity_q;
  assign out_count  = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed cases with literal expectations, then random
// traffic checked every cycle against a queue-based model of the pipeline.
module tb_logic_unit_pipe;
  import logic_unit_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [3:0] in_op = '0;
  logic       in_acc = 1'b0;
  logic       acc_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_f;
  logic       out_zero, out_ones, out_parity;
  logic [15:0] out_count;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] f;
    int         cyc;
  } beat_t;

  beat_t      q[$];
  logic [7:0] dlog[$];
  logic [7:0] m_acc = '0;
  int         deliveries = 0;
  int         accepts = 0;
  int         edge_cnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [7:0] ref_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = op[{a[i], b[i]}];
    return r;
  endfunction

  // A beat is visible once a full edge has passed after the edge that accepted it.
  function automatic logic model_out_valid();
    return (q.size() > 0) && (q[0].cyc + 1 < edge_cnt);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic acc, input logic clr, input logic ordy);
    logic       exp_rdy, exp_ov;
    logic [7:0] bop, fr;
    rst = r; in_valid = v; in_a = a; in_b = b; in_op = op;
    in_acc = acc; acc_clr = clr; out_ready = ordy;
    #1;
    exp_rdy = !(q.size() == 2 && !ordy);
    if (!r) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      q.delete();
      m_acc = '0;
      deliveries = 0;
    end else begin
      exp_ov = model_out_valid();
      if (exp_ov && ordy) begin
        dlog.push_back(q[0].f);
        void'(q.pop_front());
        deliveries++;
      end
      if (v && exp_rdy) begin
        bop = acc ? (clr ? 8'h00 : m_acc) : b;
        fr  = ref_f(a, bop, op);
        q.push_back('{fr, edge_cnt});
        m_acc = fr;
        accepts++;
      end else if (clr) begin
        m_acc = '0;
      end
    end
    edge_cnt++;
    @(negedge clk);
    exp_ov = model_out_valid();
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("out_count", 32'(out_count), 32'(deliveries % 65536));
    if (exp_ov) begin
      chk("out_f", 32'(out_f), 32'(q[0].f));
      chk("out_zero", 32'(out_zero), 32'(q[0].f == 8'h00));
      chk("out_ones", 32'(out_ones), 32'(q[0].f == 8'hFF));
      chk("out_parity", 32'(out_parity), 32'(^q[0].f));
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, OP_ZERO, 1'b0, 1'b0, ordy);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h00, 8'h00, OP_ZERO, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] vals[4];
    int         idx, acc0, guard;
    @(negedge clk);
    do_reset();
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_f", 32'(out_f), 32'h0);
    chk("rst_flags", 32'({out_zero, out_ones, out_parity}), 32'h0);
    chk("rst_count", 32'(out_count), 32'h0);
    #1 chk("rst_in_ready", 32'(in_ready), 32'h1);

    // AND with two-cycle latency
    cycle(1'b0, 1'b1, 8'hF0, 8'h3C, OP_AND, 1'b0, 1'b0, 1'b1);
    chk("t1_not_yet", 32'(out_valid), 32'h0);
    idle(1'b1);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_f", 32'(out_f), 32'h30);
    chk("t1_flags", 32'({out_zero, out_ones, out_parity}), 32'h0);
    idle(1'b1);

    // XOR to zero, then all-ones
    cycle(1'b0, 1'b1, 8'hAA, 8'hAA, OP_XOR, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'hAA, 8'hAA, OP_ONES, 1'b0, 1'b0, 1'b1);
    chk("t2_f0", 32'(out_f), 32'h00);
    chk("t2_zero", 32'(out_zero), 32'h1);
    idle(1'b1);
    chk("t2_f1", 32'(out_f), 32'hFF);
    chk("t2_flags1", 32'({out_zero, out_ones, out_parity}), 32'b010);
    idle(1'b1);

    // Accumulate OR chain
    cycle(1'b0, 1'b0, 8'h00, 8'h00, OP_ZERO, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 8'h01, 8'h00, OP_OR, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h02, 8'h00, OP_OR, 1'b1, 1'b0, 1'b1);
    chk("t3_f01", 32'(out_f), 32'h01);
    cycle(1'b0, 1'b1, 8'h04, 8'h00, OP_OR, 1'b1, 1'b0, 1'b1);
    chk("t3_f03", 32'(out_f), 32'h03);
    idle(1'b1);
    chk("t3_f07", 32'(out_f), 32'h07);
    cycle(1'b0, 1'b1, 8'h10, 8'h55, OP_OR, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    chk("t3_clr_accept", 32'(out_f), 32'h10);
    cycle(1'b0, 1'b1, 8'h01, 8'h00, OP_OR, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("t3_acc_after_clr", 32'(out_f), 32'h11);
    idle(1'b1);

    // Stalled consumer: only two beats fit
    do_reset();
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    dlog.delete();
    idx = 0;
    acc0 = accepts;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, vals[idx], 8'h00, OP_PASS_A, 1'b0, 1'b0, 1'b0);
      idx = accepts - acc0;
    end
    chk("t4_accepted", 32'(accepts - acc0), 32'd2);
    in_valid = 1'b1; out_ready = 1'b0;
    #1 chk("t4_in_ready_low", 32'(in_ready), 32'h0);
    guard = 0;
    while ((idx < 4 || q.size() > 0) && guard < 20) begin
      cycle(1'b0, idx < 4, vals[idx % 4], 8'h00, OP_PASS_A, 1'b0, 1'b0, 1'b1);
      idx = accepts - acc0;
      guard++;
    end
    chk("t4_drained", 32'(q.size()), 32'd0);
    chk("t4_count", 32'(out_count), 32'd4);
    for (int i = 0; i < 4; i++) chk("t4_order", 32'(dlog.size() > i ? dlog[i] : 8'hEE), 32'(vals[i]));

    // Reset while stalled with a valid result
    cycle(1'b0, 1'b1, 8'h5A, 8'h00, OP_PASS_A, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hC3, 8'h00, OP_PASS_A, 1'b0, 1'b0, 1'b0);
    chk("t5_stalled", 32'(out_valid), 32'h1);
    do_reset();
    chk("t5_out_valid", 32'(out_valid), 32'h0);
    chk("t5_out_f", 32'(out_f), 32'h0);
    chk("t5_flags", 32'({out_zero, out_ones, out_parity}), 32'h0);
    chk("t5_count", 32'(out_count), 32'h0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("t5_in_ready", 32'(in_ready), 32'h1);
    cycle(1'b0, 1'b1, 8'h5A, 8'h33, OP_PASS_B, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("t5_acc_zero", 32'(out_f), 32'h00);
    idle(1'b1);

    // Random traffic
    acc0 = accepts;
    guard = 0;
    while (accepts - acc0 < 10000 && guard < 60000) begin
      cycle(1'b0, $urandom_range(3, 0) != 0, 8'($urandom), 8'($urandom), 4'($urandom),
            1'($urandom), $urandom_range(15, 0) == 0, $urandom_range(3, 0) != 0);
      guard++;
    end
    chk("t6_beats", 32'(accepts - acc0 >= 10000), 32'h1);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      idle(1'b1);
      guard++;
    end
    chk("t6_drained", 32'(q.size()), 32'd0);
    chk("t6_count", 32'(out_count), 32'(deliveries % 65536));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
